// File: rtl/ocm_block_copier_pkg.sv
// Shared types and constants for the on-chip-memory block copier.
package ocm_copier_pkg;

  localparam int ADDR_W_DEF       = 12;
  localparam int DATA_W_DEF       = 32;
  localparam int MAX_READ_LATENCY = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT,
    ST_WRITE,
    ST_FIN
  } state_e;

endpackage

// File: rtl/ocm_block_copier_if.sv
// Avalon-MM bus between the copier (master) and the single-port on-chip memory (slave).
interface ocm_block_copier_if
  import ocm_copier_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic [ADDR_W-1:0]   m_address;
  logic [DATA_W/8-1:0] m_byteenable;
  logic                m_chipselect;
  logic                m_write;
  logic [DATA_W-1:0]   m_writedata;
  logic                m_clken;
  logic [DATA_W-1:0]   m_readdata;

  modport master (
    output m_address, m_byteenable, m_chipselect, m_write, m_writedata, m_clken,
    input  m_readdata
  );

  modport slave (
    input  m_address, m_byteenable, m_chipselect, m_write, m_writedata, m_clken,
    output m_readdata
  );

endinterface

// File: rtl/ocm_copy_accum.sv
// Modulo-2^DATA_W running sum of captured read words, cleared on each accepted copy.
module ocm_copy_accum #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] din_i,
  output logic [DATA_W-1:0] sum_o
);

  logic [DATA_W-1:0] sum_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sum_q <= '0;
    end else if (clr_i) begin
      sum_q <= '0;
    end else if (en_i) begin
      sum_q <= sum_q + din_i;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/ocm_block_copier.sv
// Forward block copier for the on-chip memory: read one word, write it, repeat.
// Optional checksum output enabled by defining OCM_COPY_CHECKSUM_EN.
module ocm_block_copier
  import ocm_copier_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int READ_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   src_addr,
  input  logic [ADDR_W-1:0]   dst_addr,
  input  logic [ADDR_W:0]     length,
  output logic                busy,
  output logic                done,
`ifdef OCM_COPY_CHECKSUM_EN
  output logic [DATA_W-1:0]   checksum,
`endif
  ocm_block_copier_if.master  bus
);

  localparam int WAIT_W = $clog2(MAX_READ_LATENCY);
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(READ_LATENCY - 1);

  state_e              state_q;
  logic [ADDR_W-1:0]   src_q;
  logic [ADDR_W-1:0]   dst_q;
  logic [ADDR_W:0]     remain_q;
  logic [WAIT_W-1:0]   wait_q;
  logic                busy_q;
  logic                done_q;
  logic                cs_q;
  logic                write_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                clken_q;

  // Outputs are set on the transition into a state so they are valid for that whole state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      remain_q <= '0;
      wait_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cs_q     <= 1'b0;
      write_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      clken_q  <= 1'b0;
    end else begin
      clken_q <= 1'b1;
      done_q  <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            src_q    <= src_addr;
            dst_q    <= dst_addr;
            remain_q <= length;
            if (length == '0) begin
              state_q <= ST_FIN;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_READ;
              busy_q  <= 1'b1;
              cs_q    <= 1'b1;
              write_q <= 1'b0;
              addr_q  <= src_addr;
            end
          end
        end
        ST_READ: begin
          state_q <= ST_WAIT;
          cs_q    <= 1'b0;
          wait_q  <= WAIT_LOAD;
        end
        ST_WAIT: begin
          if (wait_q == '0) begin
            // Read data doubles as the write-data register.
            state_q <= ST_WRITE;
            cs_q    <= 1'b1;
            write_q <= 1'b1;
            addr_q  <= dst_q;
            wdata_q <= bus.m_readdata;
          end else begin
            wait_q <= wait_q - 1'b1;
          end
        end
        ST_WRITE: begin
          src_q    <= src_q + 1'b1;
          dst_q    <= dst_q + 1'b1;
          remain_q <= remain_q - 1'b1;
          write_q  <= 1'b0;
          if (remain_q == (ADDR_W+1)'(1)) begin
            state_q <= ST_FIN;
            cs_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= ST_READ;
            cs_q    <= 1'b1;
            addr_q  <= src_q + 1'b1;
          end
        end
        ST_FIN: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign bus.m_address    = addr_q;
  assign bus.m_byteenable = '1;
  assign bus.m_chipselect = cs_q;
  assign bus.m_write      = write_q;
  assign bus.m_writedata  = wdata_q;
  assign bus.m_clken      = clken_q;

`ifdef OCM_COPY_CHECKSUM_EN
  logic accum_clr;
  logic accum_en;

  assign accum_clr = (state_q == ST_IDLE) && start;
  assign accum_en  = (state_q == ST_WAIT) && (wait_q == '0);

  ocm_copy_accum #(
    .DATA_W (DATA_W)
  ) u_accum (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_i   (accum_clr),
    .en_i    (accum_en),
    .din_i   (bus.m_readdata),
    .sum_o   (checksum)
  );
`endif

endmodule
